// File: rtl/db_pkg.sv
// Shared debounce definitions: per-channel FSM state encodings and parameter defaults.
package db_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_e;

  localparam int DB_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/db_channel.sv
// One debounce channel: two-flop synchronizer, then a stability FSM with a saturating-by-design counter.
// The level changes DB_CYCLES edges after the synchronized sample first differs from it; edge_pulse marks that cycle.
module db_channel
  import db_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic edge_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             edge_q, edge_d;

  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      edge_q  <= edge_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    edge_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          edge_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          edge_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level      = level_q;
  assign edge_pulse = edge_q;

endmodule

// File: rtl/dual_debounce.sv
// Two independent debounce channels (X and Y) sharing clock and reset; wiring only.
module dual_debounce
  import db_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_x,
  input  logic sw_y,
  output logic x,
  output logic y,
  output logic x_edge,
  output logic y_edge
);

  db_channel #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_x (
    .clk        (clk),
    .rst        (rst),
    .raw        (sw_x),
    .level      (x),
    .edge_pulse (x_edge)
  );

  db_channel #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_y (
    .clk        (clk),
    .rst        (rst),
    .raw        (sw_y),
    .level      (y),
    .edge_pulse (y_edge)
  );

endmodule

// File: tb/tb_dual_debounce.sv
// Bench for dual_debounce (DB_CYCLES=4): sliding-window reference model plus directed latency scenarios and random bouncing.
module tb_dual_debounce;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_x = 1'b1;
  logic sw_y = 1'b1;
  logic x, y, x_edge, y_edge;

  int n_vec = 0;
  int n_err = 0;

  dual_debounce #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_x   (sw_x),
    .sw_y   (sw_y),
    .x      (x),
    .y      (y),
    .x_edge (x_edge),
    .y_edge (y_edge)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: output flips once the last DB synchronized samples all disagree with it.
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_out[2];
  logic m_edg[2];
  logic m_hist[2][DB];
  bit   model_ok = 1'b0;

  always @(posedge clk) begin
    logic raw_c [2];
    raw_c[0] = sw_x;
    raw_c[1] = sw_y;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_s1[c] = 1'b0;
        m_s2[c] = 1'b0;
        m_out[c] = 1'b0;
        m_edg[c] = 1'b0;
        for (int i = 0; i < DB; i++) m_hist[c][i] = 1'b0;
      end else begin
        int ndiff;
        for (int i = DB - 1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
        m_hist[c][0] = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw_c[c];
        ndiff = 0;
        for (int i = 0; i < DB; i++) if (m_hist[c][i] != m_out[c]) ndiff++;
        m_edg[c] = (ndiff == DB);
        if (ndiff == DB) m_out[c] = ~m_out[c];
      end
    end
    if (rst) model_ok = 1'b1;
    #1;
    if (model_ok) begin
      chk("model_x", int'(x), int'(m_out[0]));
      chk("model_y", int'(y), int'(m_out[1]));
      chk("model_x_edge", int'(x_edge), int'(m_edg[0]));
      chk("model_y_edge", int'(y_edge), int'(m_edg[1]));
    end
  end

  // Observe maxc cycles: first cycle each output changed (0 = never), edge pulse counts.
  task automatic measure(input int maxc, output int nx, output int ny,
                         output int ex, output int ey, output int eboth);
    logic x0, y0;
    x0 = x; y0 = y;
    nx = 0; ny = 0; ex = 0; ey = 0; eboth = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (nx == 0 && x != x0) nx = i;
      if (ny == 0 && y != y0) ny = i;
      if (x_edge) ex++;
      if (y_edge) ey++;
      if (x_edge && y_edge) eboth++;
    end
  endtask

  int nx, ny, ex, ey, eb;
  int hx, hy;

  initial begin
    // Reset held 3 cycles with both raw inputs high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_edges", int'(x_edge) + int'(y_edge), 0);
    end
    rst = 1'b0;
    measure(12, nx, ny, ex, ey, eb);
    chk("rel_x_lat", nx, 6);
    chk("rel_y_lat", ny, 6);
    chk("rel_x_edges", ex, 1);
    chk("rel_y_edges", ey, 1);

    sw_x = 1'b0; sw_y = 1'b0;
    measure(12, nx, ny, ex, ey, eb);
    chk("fall_both_lat", nx + ny, 12);

    // X rises alone.
    sw_x = 1'b1;
    measure(12, nx, ny, ex, ey, eb);
    chk("x_rise_lat", nx, 6);
    chk("x_rise_edges", ex, 1);
    chk("y_quiet_lat", ny, 0);
    chk("y_quiet_edges", ey, 0);
    chk("y_quiet_lvl", int'(y), 0);

    // Short 3-cycle pulse on X is rejected.
    sw_x = 1'b0;
    measure(12, nx, ny, ex, ey, eb);
    sw_x = 1'b1;
    repeat (3) @(negedge clk);
    sw_x = 1'b0;
    measure(12, nx, ny, ex, ey, eb);
    chk("x_glitch_lat", nx, 0);
    chk("x_glitch_edges", ex, 0);
    chk("x_glitch_lvl", int'(x), 0);

    // Y falls with a bounce; latency is measured from the final 1->0.
    sw_y = 1'b1;
    measure(12, nx, ny, ex, ey, eb);
    sw_y = 1'b0;
    @(negedge clk);
    sw_y = 1'b1;
    repeat (2) @(negedge clk);
    sw_y = 1'b0;
    measure(12, nx, ny, ex, ey, eb);
    chk("y_bounce_lat", ny, 6);
    chk("y_bounce_edges", ey, 1);

    // Simultaneous rise.
    sw_x = 1'b1; sw_y = 1'b1;
    measure(12, nx, ny, ex, ey, eb);
    chk("both_x_lat", nx, 6);
    chk("both_y_lat", ny, 6);
    chk("both_same_cycle_edges", eb, 1);

    // Reset two cycles into WAIT_HI discards the pending rise.
    sw_x = 1'b0; sw_y = 1'b0;
    measure(12, nx, ny, ex, ey, eb);
    sw_x = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midwait_x", int'(x), 0);
    chk("midwait_edge", int'(x_edge), 0);
    rst = 1'b0;
    measure(12, nx, ny, ex, ey, eb);
    chk("midwait_restart_lat", nx, 6);
    chk("midwait_restart_edges", ex, 1);

    // Random bouncing on both channels, occasional reset.
    hx = 0; hy = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hx == 0) begin
        sw_x = 1'($urandom_range(0, 1));
        hx = ($urandom_range(0, 2) == 0) ? $urandom_range(4, 10) : $urandom_range(1, 3);
      end
      if (hy == 0) begin
        sw_y = 1'($urandom_range(0, 1));
        hy = ($urandom_range(0, 2) == 0) ? $urandom_range(4, 10) : $urandom_range(1, 3);
      end
      hx--; hy--;
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
